// File: rtl/condicionador_botoes.sv
// condicionador_botoes
//   Conditions the raw push-buttons for the jogo_playseq datapath. The raw
//   vector is synchronised, debounced as a whole, and each accepted
//   single-button press is reported once. It is reported as a held one-hot
//   code (jogada) together with a one-cycle pulse (tem_jogada). A press with
//   two or more buttons down is rejected and flagged with a one-cycle pulse
//   on multipla.
// Ports
//   clock         rising-edge clock
//   reset         synchronous reset, active low
//   botoes        raw asynchronous buttons, 1 = pressed
//   habilita      1 = presses may be accepted
//   limpa         clears the stored jogada (a same-edge load wins)
//   jogada        last accepted press, one-hot, held
//   tem_jogada    1-cycle pulse when a new jogada is accepted
//   jogada_valida jogada != 0
//   multipla      1-cycle pulse when more than one button is pressed together
//   db_filtrado   debounced button vector (debug)
//   db_estado     FSM state code (debug)
module condicionador_botoes #(
  parameter int N_BOTOES = 4,
  parameter int DEBOUNCE = 20,
  parameter int CW       = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] botoes,
  input  logic                habilita,
  input  logic                limpa,
  output logic [N_BOTOES-1:0] jogada,
  output logic                tem_jogada,
  output logic                jogada_valida,
  output logic                multipla,
  output logic [N_BOTOES-1:0] db_filtrado,
  output logic [2:0]          db_estado
);

  typedef enum logic [2:0] {
    INICIAL  = 3'd0,
    ESPERA   = 3'd1,
    REGISTRA = 3'd2,
    ERRO     = 3'd3,
    SOLTAR   = 3'd4
  } estado_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  estado_t             estado;
  logic [N_BOTOES-1:0] sync1, s, s_prev, filtrado;
  logic [CW-1:0]       cnt;

  // x & (x-1) clears the lowest set bit: nonzero means two or more bits set.
  logic [N_BOTOES-1:0] resto;
  logic                um_so, varios, carrega, solto;

  assign resto   = filtrado & (filtrado - 1'b1);
  assign um_so   = (filtrado != '0) && (resto == '0);
  assign varios  = (resto != '0);
  assign carrega = (estado == ESPERA) && habilita && um_so;
  // Leaving SOLTAR also requires the synchroniser to be idle. After a reset
  // taken mid-press, filtrado is 0 but the button is still down. Looking at
  // sync1/s stops that held button from being taken as a fresh press once
  // it debounces.
  assign solto   = (filtrado == '0) && (s == '0) && (sync1 == '0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1    <= '0;
      s        <= '0;
      s_prev   <= '0;
      filtrado <= '0;
      cnt      <= '0;
      jogada   <= '0;
      estado   <= INICIAL;
    end else begin
      sync1  <= botoes;
      s      <= sync1;
      s_prev <= s;

      // One counter for the whole vector: any bit change restarts the window.
      // Once the window completes, cnt parks at its last value.
      if (s != s_prev)          cnt      <= '0;
      else if (cnt == CNT_LAST) filtrado <= s;
      else                      cnt      <= cnt + 1'b1;

      if (carrega)    jogada <= filtrado;
      else if (limpa) jogada <= '0;

      case (estado)
        INICIAL:  estado <= SOLTAR;
        SOLTAR:   if (solto) estado <= ESPERA;
        ESPERA: begin
          if (habilita && um_so)       estado <= REGISTRA;
          else if (habilita && varios) estado <= ERRO;
        end
        REGISTRA: estado <= SOLTAR;
        ERRO:     estado <= SOLTAR;
        default:  estado <= INICIAL;
      endcase
    end
  end

  // Pulses are pure state decodes, so no path exists from botoes to outputs.
  assign tem_jogada    = (estado == REGISTRA);
  assign multipla      = (estado == ERRO);
  assign jogada_valida = (jogada != '0);
  assign db_filtrado   = filtrado;
  assign db_estado     = estado;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Testbench for condicionador_botoes: hand sequences for reset, latency,
// bounce, limpa/load collision and mid-press reset; a vector table for the
// multi-press, habilita and limpa scenarios.
module tb_condicionador_botoes;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] botoes;
  logic       habilita, limpa;
  logic [3:0] jogada, db_filtrado;
  logic       tem_jogada, jogada_valida, multipla;
  logic [2:0] db_estado;

  int n_vec = 0;
  int n_err = 0;
  int n_tem = 0;
  int n_mul = 0;

  condicionador_botoes #(.N_BOTOES(4), .DEBOUNCE(20), .CW(5)) dut (
    .clock(clock), .reset(reset), .botoes(botoes), .habilita(habilita),
    .limpa(limpa), .jogada(jogada), .tem_jogada(tem_jogada),
    .jogada_valida(jogada_valida), .multipla(multipla),
    .db_filtrado(db_filtrado), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // Pulse counters sampled mid-cycle; a pulse wider than one cycle counts twice.
  always @(negedge clock) begin
    if (tem_jogada === 1'b1) n_tem++;
    if (multipla === 1'b1)   n_mul++;
  end

  typedef struct {
    logic [3:0] b;
    logic       hab;
    logic       lim;
    int         cyc;
    logic [3:0] jog;
    logic       val;
    int         dtem;
    int         dmul;
    logic [2:0] est;
  } vec_t;

  vec_t tbl[11];

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic release_all();
    botoes = 4'b0000;
    repeat (30) tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0, m0;
    logic early;

    // Scenario table: apply inputs for cyc cycles, then check held outputs,
    // pulse counts and state.
    tbl[0]  = '{4'b0101, 1'b1, 1'b0, 40, 4'b0100, 1'b1, 0, 1, 3'd4}; // multi -> ERRO, jogada kept
    tbl[1]  = '{4'b0000, 1'b1, 1'b0, 30, 4'b0100, 1'b1, 0, 0, 3'd1};
    tbl[2]  = '{4'b1000, 1'b1, 1'b0, 30, 4'b1000, 1'b1, 1, 0, 3'd4};
    tbl[3]  = '{4'b0000, 1'b1, 1'b0, 30, 4'b1000, 1'b1, 0, 0, 3'd1};
    tbl[4]  = '{4'b0001, 1'b0, 1'b0, 30, 4'b1000, 1'b1, 0, 0, 3'd1}; // habilita=0 press
    tbl[5]  = '{4'b0000, 1'b0, 1'b0, 30, 4'b1000, 1'b1, 0, 0, 3'd1}; // and release
    tbl[6]  = '{4'b0001, 1'b0, 1'b0, 30, 4'b1000, 1'b1, 0, 0, 3'd1}; // held, disabled
    tbl[7]  = '{4'b0001, 1'b1, 1'b0,  3, 4'b0001, 1'b1, 1, 0, 3'd4}; // habilita rises
    tbl[8]  = '{4'b0001, 1'b1, 1'b0, 30, 4'b0001, 1'b1, 0, 0, 3'd4}; // only once
    tbl[9]  = '{4'b0000, 1'b1, 1'b0, 30, 4'b0001, 1'b1, 0, 0, 3'd1};
    tbl[10] = '{4'b0000, 1'b1, 1'b1,  1, 4'b0000, 1'b0, 0, 0, 3'd1}; // limpa, no press

    botoes = 4'b0000; habilita = 1'b0; limpa = 1'b0; reset = 1'b0;

    // 1. reset
    tick();
    check("rst_estado", db_estado, 3'd0);
    check("rst_jogada", jogada, 4'b0000);
    check("rst_tem", tem_jogada, 1'b0);
    check("rst_multipla", multipla, 1'b0);
    reset = 1'b1;
    tick();
    check("rst_estado_soltar", db_estado, 3'd4);
    tick();
    check("rst_estado_espera", db_estado, 3'd1);

    // 2. single press latency, held 100 cycles
    habilita = 1'b1;
    botoes = 4'b0010;
    t0 = n_tem;
    early = 1'b0;
    for (int e = 0; e < 100; e++) begin
      tick();
      if (e < 23 && tem_jogada === 1'b1) early = 1'b1;
      if (e == 21) check("lat_filtrado_before", db_filtrado, 4'b0000);
      if (e == 22) check("lat_filtrado_edge22", db_filtrado, 4'b0010);
      if (e == 23) begin
        check("lat_tem_edge23", tem_jogada, 1'b1);
        check("lat_jogada", jogada, 4'b0010);
        check("lat_valida", jogada_valida, 1'b1);
      end
      if (e == 24) check("lat_tem_width", tem_jogada, 1'b0);
    end
    check("lat_no_early", early, 1'b0);
    check("lat_one_pulse", n_tem - t0, 1);
    release_all();

    // 3. bouncing press: 5 on / 3 off for 40 cycles, then stable
    t0 = n_tem;
    for (int p = 0; p < 5; p++) begin
      botoes = 4'b0100; repeat (5) tick();
      botoes = 4'b0000; repeat (3) tick();
    end
    check("bounce_no_pulse", n_tem - t0, 0);
    check("bounce_filtrado", db_filtrado, 4'b0000);
    botoes = 4'b0100;
    for (int e = 0; e < 24; e++) begin
      tick();
      if (e == 22) check("bounce_tem_edge22", tem_jogada, 1'b0);
      if (e == 23) check("bounce_tem_edge23", tem_jogada, 1'b1);
    end
    repeat (10) tick();
    check("bounce_one_pulse", n_tem - t0, 1);
    check("bounce_jogada", jogada, 4'b0100);
    release_all();

    // 4/5. table-driven scenarios
    for (int i = 0; i < 11; i++) begin
      botoes = tbl[i].b; habilita = tbl[i].hab; limpa = tbl[i].lim;
      t0 = n_tem; m0 = n_mul;
      repeat (tbl[i].cyc) tick();
      check($sformatf("vec%0d_jogada", i), jogada, tbl[i].jog);
      check($sformatf("vec%0d_valida", i), jogada_valida, tbl[i].val);
      check($sformatf("vec%0d_tem_count", i), n_tem - t0, tbl[i].dtem);
      check($sformatf("vec%0d_mul_count", i), n_mul - m0, tbl[i].dmul);
      check($sformatf("vec%0d_estado", i), db_estado, tbl[i].est);
    end
    limpa = 1'b0;

    // 6b. limpa held across the load edge: the new press is stored
    botoes = 4'b0010; limpa = 1'b1;
    for (int e = 0; e < 24; e++) begin
      tick();
      if (e == 22) check("limpa_load_before", jogada, 4'b0000);
    end
    check("limpa_load_jogada", jogada, 4'b0010);
    check("limpa_load_tem", tem_jogada, 1'b1);
    limpa = 1'b0;
    repeat (10) tick();
    check("limpa_load_hold", jogada, 4'b0010);
    release_all();

    // 6c. reset in the middle of a held press
    botoes = 4'b0100;
    repeat (15) tick();
    reset = 1'b0;
    tick();
    check("midrst_estado", db_estado, 3'd0);
    check("midrst_jogada", jogada, 4'b0000);
    check("midrst_filtrado", db_filtrado, 4'b0000);
    reset = 1'b1;
    t0 = n_tem;
    repeat (60) tick();
    check("midrst_no_pulse", n_tem - t0, 0);
    check("midrst_estado_soltar", db_estado, 3'd4);
    check("midrst_filtrado_held", db_filtrado, 4'b0100);
    check("midrst_jogada_clear", jogada, 4'b0000);
    release_all();
    check("midrst_release_espera", db_estado, 3'd1);
    botoes = 4'b0100;
    repeat (30) tick();
    check("midrst_repress_pulse", n_tem - t0, 1);
    check("midrst_repress_jogada", jogada, 4'b0100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
